bram_port_arbiter: RTL and testbench

Round-robin arbiter that multiplexes `NumClients` request/response channels onto a single block RAM port (one `portN_*` of `BlockRAM_2RW`). It sits directly upstream of the RAM port and captures each RAM response into a one-entry registered return stage, then routes the response back to the client that issued it. Sustains one access per cycle when clients drain responses promptly.

---
 rtl/bram_port_arbiter.sv | 113 +++++++++++
 tb/tb_bram_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block RAM port among NumClients channels.
// Each RAM response is captured in a one-entry return stage and routed back to its issuer.
module bram_port_arbiter #(
    parameter int Width           = 8,
    parameter int AddrWidth       = 8,
    parameter int NumClients      = 2,
    parameter int CLog2NumClients = 1,
    localparam int ReqW           = Width + AddrWidth + 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [ReqW-1:0]            client_reqs [NumClients],
    input  logic [NumClients-1:0]      client_req_valids,
    output logic [NumClients-1:0]      client_req_bps,
    output logic [Width-1:0]           client_resps [NumClients],
    output logic [NumClients-1:0]      client_resp_valids,
    input  logic [NumClients-1:0]      client_resp_bps,
    output logic [ReqW-1:0]            mem_req,
    output logic                       mem_req_valid,
    input  logic                       mem_req_bp,
    input  logic [Width-1:0]           mem_resp,
    input  logic                       mem_resp_valid,
    output logic                       mem_resp_bp
);

    logic [CLog2NumClients-1:0] rr_ptr_q, rr_ptr_d;
    logic                       out_valid_q, out_valid_d;
    logic [CLog2NumClients-1:0] out_owner_q, out_owner_d;
    logic [Width-1:0]           out_data_q, out_data_d;

    logic [CLog2NumClients-1:0] grant_s;
    logic                       any_valid_s;
    logic                       drain_s;
    logic                       slot_free_s;
    logic                       xfer_s;

    // Grant = valid client with the smallest wrapped distance from rr_ptr.
    always_comb begin
        int dist_v;
        int best_v;
        grant_s     = '0;
        any_valid_s = 1'b0;
        best_v      = NumClients;
        for (int i = 0; i < NumClients; i++) begin
            dist_v = i - int'(rr_ptr_q);
            if (dist_v < 0) begin
                dist_v = dist_v + NumClients;
            end else begin
                dist_v = dist_v;
            end
            if (client_req_valids[i] && (dist_v < best_v)) begin
                best_v      = dist_v;
                grant_s     = CLog2NumClients'(i);
                any_valid_s = 1'b1;
            end else begin
                best_v      = best_v;
            end
        end
    end

    // Handshake terms and client-facing outputs.
    always_comb begin
        drain_s       = out_valid_q & ~client_resp_bps[out_owner_q];
        slot_free_s   = ~out_valid_q | drain_s;
        mem_req       = client_reqs[grant_s];
        mem_req_valid = any_valid_s & slot_free_s;
        mem_resp_bp   = ~slot_free_s;
        xfer_s        = mem_req_valid & ~mem_req_bp & mem_resp_valid;
        for (int i = 0; i < NumClients; i++) begin
            client_req_bps[i]     = ~(xfer_s & (grant_s == CLog2NumClients'(i)));
            client_resp_valids[i] = out_valid_q & (out_owner_q == CLog2NumClients'(i));
            client_resps[i]       = out_data_q;
        end
    end

    // Return-stage and pointer update; a drain in the same cycle as a transfer is a refill.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_owner_d = out_owner_q;
        out_data_d  = out_data_q;
        if (xfer_s) begin
            out_data_d  = mem_resp;
            out_owner_d = grant_s;
            out_valid_d = 1'b1;
            if (grant_s == CLog2NumClients'(NumClients - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_s + CLog2NumClients'(1);
            end
        end else if (drain_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; reset discards any held response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_owner_q <= '0;
            out_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_owner_q <= out_owner_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: directed stimulus pushes expected responses,
// a negedge monitor pops them whenever a client consumes a response.
module tb_bram_port_arbiter;

    localparam int W  = 8;
    localparam int AW = 8;
    localparam int NC = 2;
    localparam int RW = W + AW + 1;

    typedef struct {
        int           owner;
        logic [W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              resetn;
    logic [RW-1:0]     client_reqs [NC];
    logic [NC-1:0]     client_req_valids;
    logic [NC-1:0]     client_req_bps;
    logic [W-1:0]      client_resps [NC];
    logic [NC-1:0]     client_resp_valids;
    logic [NC-1:0]     client_resp_bps;
    logic [RW-1:0]     mem_req;
    logic              mem_req_valid;
    logic              mem_req_bp;
    logic [W-1:0]      mem_resp;
    logic              mem_resp_valid;
    logic              mem_resp_bp;

    logic [W-1:0] ram [256] = '{1: 8'h11, 2: 8'h22, 5: 8'hA5, default: 8'h00};

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    bram_port_arbiter #(
        .Width(W), .AddrWidth(AW), .NumClients(NC), .CLog2NumClients(1)
    ) dut (
        .clk(clk), .resetn(resetn),
        .client_reqs(client_reqs), .client_req_valids(client_req_valids),
        .client_req_bps(client_req_bps), .client_resps(client_resps),
        .client_resp_valids(client_resp_valids), .client_resp_bps(client_resp_bps),
        .mem_req(mem_req), .mem_req_valid(mem_req_valid), .mem_req_bp(mem_req_bp),
        .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid), .mem_resp_bp(mem_resp_bp)
    );

    always #5 clk = ~clk;

    // RAM model: same-cycle read of old data, write on accepted transfer.
    assign mem_resp = ram[mem_req[RW-1:W+1]];
    always @(posedge clk) begin
        if (mem_req_valid && !mem_req_bp && mem_resp_valid && mem_req[0])
            ram[mem_req[RW-1:W+1]] <= mem_req[W:1];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [RW-1:0] mk(input logic [7:0] a, input logic [7:0] d, input logic wr);
        return {a, d, wr};
    endfunction

    task automatic expect_resp(input int owner, input logic [W-1:0] data);
        exp_t e;
        e.owner = owner;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    // Monitor: every consumed response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (resetn) begin
            for (int i = 0; i < NC; i++) begin
                if (client_resp_valids[i] && !client_resp_bps[i]) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_resp: client %0d data 0x%0h, none expected", i, client_resps[i]);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("resp_owner", 32'(i), 32'(e.owner));
                        chk("resp_data", 32'(client_resps[i]), 32'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        resetn             = 1'b0;
        client_req_valids  = 2'b00;
        client_resp_bps    = 2'b00;
        mem_req_bp         = 1'b0;
        mem_resp_valid     = 1'b1;
        client_reqs[0]     = '0;
        client_reqs[1]     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valids", 32'(client_resp_valids), 32'(2'b00));
        chk("rst_req_bps", 32'(client_req_bps), 32'(2'b11));
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'(1'b0));
        chk("rst_mem_resp_bp", 32'(mem_resp_bp), 32'(1'b0));
        resetn = 1'b1;

        // Single read: client1 reads addr 5
        @(posedge clk); #1;
        client_reqs[1] = mk(8'd5, 8'd0, 1'b0);
        client_req_valids = 2'b10;
        expect_resp(1, 8'hA5);
        @(negedge clk);
        chk("single_req_bps", 32'(client_req_bps), 32'(2'b01));
        chk("single_mem_req_valid", 32'(mem_req_valid), 32'(1'b1));
        @(posedge clk); #1;
        client_req_valids = 2'b00;
        @(negedge clk);
        chk("single_resp_valids", 32'(client_resp_valids), 32'(2'b10));

        // Round-robin fairness: pointer wrapped to 0, so client0 goes first
        @(posedge clk); #1;
        client_reqs[0] = mk(8'd1, 8'd0, 1'b0);
        client_reqs[1] = mk(8'd2, 8'd0, 1'b0);
        client_req_valids = 2'b11;
        for (int k = 0; k < 4; k++) begin
            expect_resp(k % 2, (k % 2 == 0) ? 8'h11 : 8'h22);
            @(negedge clk);
            chk("rr_req_bps", 32'(client_req_bps), (k % 2 == 0) ? 32'(2'b10) : 32'(2'b01));
            @(posedge clk);
        end
        #1 client_req_valids = 2'b00;
        repeat (2) @(posedge clk);

        // Write then read: read-old returns 0x00, then 0x3C
        #1;
        client_reqs[0] = mk(8'd7, 8'h3C, 1'b1);
        client_req_valids = 2'b01;
        expect_resp(0, 8'h00);
        @(negedge clk);
        chk("wr_req_bps", 32'(client_req_bps), 32'(2'b10));
        @(posedge clk); #1;
        client_reqs[0] = mk(8'd7, 8'h00, 1'b0);
        expect_resp(0, 8'h3C);
        @(negedge clk);
        chk("rd_req_bps", 32'(client_req_bps), 32'(2'b10));
        @(posedge clk); #1;
        client_req_valids = 2'b00;
        repeat (2) @(posedge clk);

        // Response stall: client0 holds bp for 3 cycles while client1 waits
        #1;
        client_reqs[0] = mk(8'd1, 8'd0, 1'b0);
        client_req_valids = 2'b01;
        client_resp_bps = 2'b01;
        expect_resp(0, 8'h11);
        @(negedge clk);
        chk("stall_first_bps", 32'(client_req_bps), 32'(2'b10));
        @(posedge clk); #1;
        client_reqs[1] = mk(8'd2, 8'd0, 1'b0);
        client_req_valids = 2'b10;
        expect_resp(1, 8'h22);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_mem_req_valid", 32'(mem_req_valid), 32'(1'b0));
            chk("stall_req_bps", 32'(client_req_bps), 32'(2'b11));
            chk("stall_mem_resp_bp", 32'(mem_resp_bp), 32'(1'b1));
            chk("stall_resp_valids", 32'(client_resp_valids), 32'(2'b01));
            @(posedge clk);
        end
        #1 client_resp_bps = 2'b00;
        @(negedge clk);
        chk("refill_req_bps", 32'(client_req_bps), 32'(2'b01));
        chk("refill_mem_req_valid", 32'(mem_req_valid), 32'(1'b1));
        @(posedge clk); #1;
        client_req_valids = 2'b00;
        repeat (2) @(posedge clk);

        // RAM backpressure: no transfer, grant held on client0
        #1;
        mem_req_bp = 1'b1;
        client_req_valids = 2'b11;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rambp_req_bps", 32'(client_req_bps), 32'(2'b11));
            chk("rambp_mem_req_valid", 32'(mem_req_valid), 32'(1'b1));
            chk("rambp_mem_req", 32'(mem_req), 32'(mk(8'd1, 8'd0, 1'b0)));
            @(posedge clk);
        end
        #1 mem_req_bp = 1'b0;
        expect_resp(0, 8'h11);
        expect_resp(1, 8'h22);
        @(negedge clk);
        chk("rambp_resume0", 32'(client_req_bps), 32'(2'b10));
        @(posedge clk);
        @(negedge clk);
        chk("rambp_resume1", 32'(client_req_bps), 32'(2'b01));
        @(posedge clk); #1;
        client_req_valids = 2'b00;
        repeat (2) @(posedge clk);

        // Mid-operation reset discards a held response
        #1;
        client_reqs[1] = mk(8'd5, 8'd0, 1'b0);
        client_req_valids = 2'b10;
        client_resp_bps = 2'b10;
        @(negedge clk);
        chk("hold_req_bps", 32'(client_req_bps), 32'(2'b01));
        @(posedge clk); #1;
        client_req_valids = 2'b00;
        @(negedge clk);
        chk("hold_resp_valids", 32'(client_resp_valids), 32'(2'b10));
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_resp_valids", 32'(client_resp_valids), 32'(2'b00));
        chk("async_rst_req_bps", 32'(client_req_bps), 32'(2'b11));
        chk("async_rst_mem_req_valid", 32'(mem_req_valid), 32'(1'b0));
        chk("async_rst_mem_resp_bp", 32'(mem_resp_bp), 32'(1'b0));
        client_resp_bps = 2'b00;
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(posedge clk);

        // Drain scoreboard with a bounded wait
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
